// File: rtl/card_punch.sv
// Card punch controller: buffers an 80-column card image and drives the punch
// magnets row by row in reader order (9..0, 11, 12), clearing the image afterwards.
module card_punch #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4
) (
  input  logic        inclk,
  input  logic        reset,
  input  logic        col_we,
  input  logic [6:0]  col_sel,
  input  logic [3:0]  col_code,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] punch_row,
  output logic [0:79] punch_cols
);

  // state | meaning
  // IDLE  | waiting for start, image writable
  // PULSE | magnets energised for the current row
  // GAP   | magnets released between rows
  // DONE  | one-cycle completion pulse, image cleared to blank

  localparam int MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] P_LOAD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] G_LOAD = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic [3:0]    img_q [80];
  logic [3:0]    img_d [80];
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [15:0]   punch_row_q, punch_row_d;
  logic [0:79]   punch_cols_q, punch_cols_d;
  logic [3:0]    cur_row;

  function automatic logic [3:0] seq_row(input logic [3:0] idx);
    if (idx < 4'd10)       return 4'd9 - idx;
    else if (idx == 4'd10) return 4'd11;
    else                   return 4'd12;
  endfunction

  // Row 15 never appears in the sequence, so it doubles as "blank".
  function automatic logic [3:0] code_row(input logic [3:0] code);
    if (code < 4'd10)       return code;
    else if (code == 4'd10) return 4'd11;
    else if (code == 4'd11) return 4'd12;
    else                    return 4'd15;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    img_d   = img_q;
    unique case (state_q)
      S_IDLE: begin
        if (col_we && (col_sel < 7'd80)) img_d[col_sel] = col_code;
        if (start) begin
          state_d = S_PULSE;
          cnt_d   = P_LOAD;
          idx_d   = 4'd0;
        end
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = G_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          if (idx_q == 4'd11) begin
            state_d = S_DONE;
          end else begin
            state_d = S_PULSE;
            idx_d   = idx_q + 4'd1;
            cnt_d   = P_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = 4'd0;
        for (int c = 0; c < 80; c++) img_d[c] = 4'hF;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d       = (state_d == S_PULSE) || (state_d == S_GAP);
    done_d       = (state_d == S_DONE);
    cur_row      = seq_row(idx_d);
    punch_row_d  = '0;
    punch_cols_d = '0;
    // Columns come from the post-write image so a same-cycle write is punched.
    if (state_d == S_PULSE) begin
      punch_row_d = 16'(1) << cur_row;
      for (int c = 0; c < 80; c++) punch_cols_d[c] = (code_row(img_d[c]) == cur_row);
    end
  end

  always_ff @(posedge inclk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      img_q        <= '{default: 4'hF};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      punch_row_q  <= '0;
      punch_cols_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      img_q        <= img_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      punch_row_q  <= punch_row_d;
      punch_cols_q <= punch_cols_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign punch_row  = punch_row_q;
  assign punch_cols = punch_cols_q;

endmodule

// File: tb/tb_card_punch.sv
// Directed bench for card_punch: checks every cycle of each card against a
// small image model plus hand-computed snapshots of selected rows.
module tb_card_punch;
  localparam int P = 4;
  localparam int G = 4;

  logic        inclk;
  logic        reset;
  logic        col_we;
  logic [6:0]  col_sel;
  logic [3:0]  col_code;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] punch_row;
  logic [0:79] punch_cols;

  int total = 0;
  int bad   = 0;

  logic [3:0]  exp_img [80];
  logic [0:79] snap_cols [12];
  logic [15:0] snap_row [12];
  int          seq [12] = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 11, 12};

  card_punch #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .inclk(inclk), .reset(reset), .col_we(col_we), .col_sel(col_sel),
    .col_code(col_code), .start(start), .busy(busy), .done(done),
    .punch_row(punch_row), .punch_cols(punch_cols)
  );

  initial inclk = 1'b0;
  always #5 inclk = ~inclk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int row_of(input logic [3:0] code);
    if (code < 4'd10) return int'(code);
    if (code == 4'd10) return 11;
    if (code == 4'd11) return 12;
    return -1;
  endfunction

  task automatic write_col(input logic [6:0] sel, input logic [3:0] code);
    col_we = 1'b1; col_sel = sel; col_code = code;
    if (sel < 7'd80) exp_img[sel] = code;
    @(negedge inclk);
    col_we = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " done"}, done, 1'b0);
    chk({tag, " row"}, punch_row, 16'h0);
    chk({tag, " cols"}, punch_cols, 80'h0);
  endtask

  // Starts a card at the next edge and checks every cycle through one idle cycle.
  task automatic run_card(input bit we0, input logic [6:0] sel0, input logic [3:0] code0,
                          input bit lock, input int abort_n);
    logic [0:79] ec;
    logic [15:0] er;
    int cyc, k, ph;
    bit pulse;
    start = 1'b1; col_we = we0; col_sel = sel0; col_code = code0;
    if (we0 && sel0 < 7'd80) exp_img[sel0] = code0;
    @(negedge inclk);
    start = 1'b0; col_we = 1'b0;
    for (int n = 1; n <= 98; n++) begin
      cyc = n - 1;
      k = cyc / (P + G);
      ph = cyc % (P + G);
      pulse = (k < 12) && (ph < P);
      ec = '0;
      er = '0;
      if (pulse) begin
        er = 16'(1) << seq[k];
        for (int c = 0; c < 80; c++) ec[c] = (row_of(exp_img[c]) == seq[k]);
        if (ph == 0) begin
          snap_cols[k] = punch_cols;
          snap_row[k] = punch_row;
        end
      end
      chk($sformatf("row n=%0d", n), punch_row, er);
      chk($sformatf("cols n=%0d", n), punch_cols, ec);
      chk($sformatf("busy n=%0d", n), busy, (n <= 12 * (P + G)) ? 1'b1 : 1'b0);
      chk($sformatf("done n=%0d", n), done, (n == 12 * (P + G) + 1) ? 1'b1 : 1'b0);
      if (n == 12 * (P + G) + 1)
        for (int c = 0; c < 80; c++) exp_img[c] = 4'hF;
      if (lock && n == 20) begin
        start = 1'b1; col_we = 1'b1; col_sel = 7'd5; col_code = 4'd3;
      end else begin
        start = 1'b0; col_we = 1'b0;
      end
      if (abort_n != 0 && n == abort_n) begin
        reset = 1'b0;
        @(negedge inclk);
        reset = 1'b1;
        for (int c = 0; c < 80; c++) exp_img[c] = 4'hF;
        check_idle("abort");
        for (int j = 0; j < 3; j++) begin
          @(negedge inclk);
          check_idle($sformatf("post_abort j=%0d", j));
        end
        return;
      end
      @(negedge inclk);
    end
  endtask

  initial begin
    logic [0:79] hand;
    reset = 1'b0; col_we = 1'b0; col_sel = '0; col_code = '0; start = 1'b0;
    for (int c = 0; c < 80; c++) exp_img[c] = 4'hF;
    repeat (3) @(negedge inclk);
    check_idle("reset");
    reset = 1'b1;
    @(negedge inclk);

    // Unloaded card: every row pulses with no columns.
    run_card(1'b0, 7'd0, 4'd0, 1'b0, 0);

    // Digit card.
    for (int c = 0; c < 80; c++) write_col(7'(c), 4'(c % 10));
    run_card(1'b0, 7'd0, 4'd0, 1'b0, 0);
    hand = '0;
    for (int c = 9; c < 80; c += 10) hand[c] = 1'b1;
    chk("digit row9 cols", snap_cols[0], hand);
    chk("digit row9 onehot", snap_row[0], 16'h0200);

    // Zone codes, blank code and an out-of-range column.
    write_col(7'd20, 4'd10);
    write_col(7'd21, 4'd11);
    write_col(7'd22, 4'd12);
    write_col(7'd100, 4'd5);
    run_card(1'b0, 7'd0, 4'd0, 1'b0, 0);
    hand = '0; hand[20] = 1'b1;
    chk("zone row11 cols", snap_cols[10], hand);
    chk("zone row11 onehot", snap_row[10], 16'h0800);
    hand = '0; hand[21] = 1'b1;
    chk("zone row12 cols", snap_cols[11], hand);
    chk("zone row12 onehot", snap_row[11], 16'h1000);

    // Start and write while busy are dropped.
    write_col(7'd40, 4'd3);
    run_card(1'b0, 7'd0, 4'd0, 1'b1, 0);
    hand = '0; hand[40] = 1'b1;
    chk("lock row3 cols", snap_cols[6], hand);
    run_card(1'b0, 7'd0, 4'd0, 1'b0, 0);
    chk("after lock row3 cols", snap_cols[6], 80'h0);

    // Write in the same IDLE cycle as start is punched.
    run_card(1'b1, 7'd0, 4'd7, 1'b0, 0);
    hand = '0; hand[0] = 1'b1;
    chk("same cycle row7 cols", snap_cols[2], hand);

    // Reset during row 4 pulse abandons the card and blanks the image.
    write_col(7'd3, 4'd4);
    run_card(1'b0, 7'd0, 4'd0, 1'b0, 42);
    run_card(1'b0, 7'd0, 4'd0, 1'b0, 0);
    chk("fresh after abort row4 cols", snap_cols[5], 80'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/card_punch.md
# card_punch

Card punch controller: the writing counterpart of the card reader that feeds the ES24. It holds an 80-column card image loaded one column at a time and, on a start command, drives the punch magnets row by row in the same row order and row numbering the reader uses for its timing pulses. This makes a punched card read back bit-identical through the reader. It sits between the tabulator result path, which supplies digit codes per column, and the punch mechanism.

## Interface
- PULSE_CYCLES, 4: cycles each row's magnets stay energised (≥1).
- GAP_CYCLES, 4: de-energised cycles after each row before the next row (≥1).
- inclk  in  1  clock.
- reset  in  1  synchronous, active-low.
- col_we  in  1  write strobe for one column of the card image.
- col_sel  in  7  column index 0..79; values 80..127 ignored.
- col_code  in  4  column code:
  - 0..9: punch digit row 0..9.
  - 10: punch row 11 (X zone).
  - 11: punch row 12 (Y zone).
  - 12..15: blank.
- start  in  1  request to punch the loaded card.
- busy  out  1  high while a card is being punched.
- done  out  1  one-cycle pulse when a card is complete.
- punch_row  out  16  one-hot row being punched; bit n = row n, same numbering as reader timing pulses; bit 10 and bits 13..15 never set.
- punch_cols  out  80  [0:79], column c high = magnet c energised for the current row.

## Operation
- Image buffer: 80 × 4-bit codes. Reset value is 15 (blank) for every column.
- Write: col_we=1 with busy=0 stores col_code at col_sel on that edge. Writes while busy=1 are dropped.
- Row sequence per card, 12 rows: 9,8,7,6,5,4,3,2,1,0,11,12. This matches the reader's pulse order.
- punch_cols[c] = 1 during a row's PULSE phase iff the code of column c maps to that row. Otherwise 0.
- FSM states:
  - IDLE: busy=0. start=1 → PULSE with row=9.
  - PULSE: punch_row one-hot and punch_cols valid. After PULSE_CYCLES → GAP.
  - GAP: punch_row=0, punch_cols=0. After GAP_CYCLES, go to PULSE with the next row; if row 12 is done, go to DONE.
  - DONE: one cycle. done=1, busy=0, every buffer entry set to 15. → IDLE.
- start while busy, or in the DONE cycle: ignored, not queued.
- col_we and start in the same IDLE cycle: the write is applied and is included in the card being punched.
- Phase counter: width sized for max(PULSE_CYCLES, GAP_CYCLES).
- Row pointer: 4-bit index 0..11 into the sequence; never wraps mid-card.

## Timing
- All outputs are registered.
- Reset (reset=0 at an edge) → next cycle:
  - busy=0, done=0, punch_row=0, punch_cols=0, buffer all 15, FSM IDLE.
- Reset mid-card: the above applies. Magnets drop the next cycle and the partial card is abandoned, with no done pulse.
- start sampled at edge t (IDLE):
  - From t+1: busy=1, punch_row[9]=1, punch_cols = row-9 columns.
  - Row k (0-based in sequence) is energised on cycles t+1+k·(P+G) .. t+k·(P+G)+P.
- Last gap ends at cycle t+12·(P+G).
- done=1 and busy=0 on cycle t+12·(P+G)+1. Buffer reads blank from t+12·(P+G)+2.
- A new start is accepted at the earliest on edge t+12·(P+G)+2.
- punch_row and punch_cols change only on phase boundaries. They are never nonzero in GAP, IDLE, or DONE.

## Test plan
- **Reset values:** hold reset=0 for 3 cycles → busy=0, done=0, punch_row=0, punch_cols=0. Then punch an unloaded card → all 12 rows pulse with punch_cols=0, and done arrives at cycle 12·8+1 after start (defaults).
- **Digit card:** load column c with code c mod 10 for c=0..79, then start → during row 9, punch_cols bits 9,19,…,79 set (8 bits), and punch_row=16'h0200. Row order is 9..0,11,12, each high exactly 4 cycles with a 4-cycle gap.
- **Zones:**
  - col 20 = 10, col 21 = 11, col 22 = 12 → punch_cols[20] only during punch_row=16'h0800, punch_cols[21] only during 16'h1000, col 22 never punched.
  - Write to col_sel=100 → no column affected.
- **Busy lockout:** during a card, pulse start and write col 5 = 3 → no second card runs; the write is lost. After done, punch again → col 5 blank.
- **Same-cycle write/start:** col_we (col 0 = 7) with start in one IDLE cycle → punch_cols[0]=1 during row 7.
- **Reset mid-card:** assert reset during row 4 PULSE → punch_row=0 and punch_cols=0 the next cycle, no done, buffer blank. A subsequent start behaves as a fresh card.
